// File: rtl/lcd_digit_writer.sv
// HD44780 8-bit sequencer: autonomous power-up/init, then DDRAM address plus three ASCII bytes per start.
// Latency: done_o pulses 4*(T_SETUP+T_PULSE+T_EXEC) cycles after start acceptance, in the first IDLE cycle.
// Backpressure: start_i is honoured only while ready_o=1; requests at any other time are dropped, not queued.
module lcd_digit_writer #(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_SETUP   = 3,
    parameter int unsigned T_PULSE   = 12,
    parameter int unsigned T_EXEC    = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter logic [6:0]  LINE_ADDR = 7'h00
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [7:0] enco1_i,
    input  logic [7:0] enco2_i,
    input  logic [7:0] enco3_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o
);
    localparam int CW = 20;
    localparam logic [CW-1:0] LIM_PWR   = CW'(T_POWERUP);
    localparam logic [CW-1:0] LIM_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LIM_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LIM_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LIM_CLEAR = CW'(T_CLEAR - 1);

    typedef enum logic [1:0] {PWRUP, INIT, IDLE, WRITE} top_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

    top_t          state;
    phase_t        phase;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [7:0]    byte1, byte2, byte3;
    logic [CW-1:0] wait_lim;
    logic [8:0]    next_byte;

    // Returns {rs, data} for byte slot i of the init (wr=0) or write (wr=1) sequence.
    function automatic logic [8:0] byte_sel(input logic wr, input logic [1:0] i,
                                            input logic [7:0] c1, input logic [7:0] c2,
                                            input logic [7:0] c3);
        logic [8:0] r;
        r = 9'h000;
        if (!wr) begin
            case (i)
                2'd0:    r = {1'b0, 8'h38};
                2'd1:    r = {1'b0, 8'h0C};
                2'd2:    r = {1'b0, 8'h01};
                default: r = {1'b0, 8'h06};
            endcase
        end else begin
            case (i)
                2'd0:    r = {2'b01, LINE_ADDR};
                2'd1:    r = {1'b1, c1};
                2'd2:    r = {1'b1, c2};
                default: r = {1'b1, c3};
            endcase
        end
        return r;
    endfunction

    // The clear command is the only byte needing the long post-pulse wait.
    always_comb begin
        wait_lim  = (!lcd_rs_o && lcd_data_o == 8'h01) ? LIM_CLEAR : LIM_EXEC;
        next_byte = byte_sel(state == WRITE, idx + 2'd1, byte1, byte2, byte3);
    end

    assign lcd_rw_o = 1'b0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= PWRUP;
            phase      <= PH_SETUP;
            cnt        <= '0;
            idx        <= 2'd0;
            byte1      <= 8'h00;
            byte2      <= 8'h00;
            byte3      <= 8'h00;
            ready_o    <= 1'b0;
            done_o     <= 1'b0;
            lcd_rs_o   <= 1'b0;
            lcd_e_o    <= 1'b0;
            lcd_data_o <= 8'h00;
        end else begin
            done_o <= 1'b0;
            case (state)
                PWRUP: begin
                    if (cnt == LIM_PWR) begin
                        state                  <= INIT;
                        phase                  <= PH_SETUP;
                        idx                    <= 2'd0;
                        cnt                    <= '0;
                        {lcd_rs_o, lcd_data_o} <= byte_sel(1'b0, 2'd0, byte1, byte2, byte3);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (start_i) begin
                        byte1                  <= enco1_i;
                        byte2                  <= enco2_i;
                        byte3                  <= enco3_i;
                        state                  <= WRITE;
                        phase                  <= PH_SETUP;
                        idx                    <= 2'd0;
                        cnt                    <= '0;
                        ready_o                <= 1'b0;
                        {lcd_rs_o, lcd_data_o} <= byte_sel(1'b1, 2'd0, byte1, byte2, byte3);
                    end
                end
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            if (cnt == LIM_SETUP) begin
                                phase   <= PH_PULSE;
                                cnt     <= '0;
                                lcd_e_o <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        PH_PULSE: begin
                            if (cnt == LIM_PULSE) begin
                                phase   <= PH_WAIT;
                                cnt     <= '0;
                                lcd_e_o <= 1'b0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (cnt == wait_lim) begin
                                cnt <= '0;
                                if (idx == 2'd3) begin
                                    state   <= IDLE;
                                    ready_o <= 1'b1;
                                    done_o  <= (state == WRITE);
                                end else begin
                                    idx                    <= idx + 2'd1;
                                    phase                  <= PH_SETUP;
                                    {lcd_rs_o, lcd_data_o} <= next_byte;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_digit_writer.sv
// Bench for lcd_digit_writer: cycle-by-cycle comparison of the LCD pins against a timeline built
// from byte lists and phase lengths, with randomized data and stray start pulses.
module tb_lcd_digit_writer;
    localparam int unsigned T_POWERUP = 10;
    localparam int unsigned T_SETUP   = 2;
    localparam int unsigned T_PULSE   = 3;
    localparam int unsigned T_EXEC    = 5;
    localparam int unsigned T_CLEAR   = 8;
    localparam logic [6:0]  LINE_ADDR = 7'h40;

    logic       clk_i   = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] enco1_i = 8'h00;
    logic [7:0] enco2_i = 8'h00;
    logic [7:0] enco3_i = 8'h00;
    logic       ready_o, done_o, lcd_rs_o, lcd_rw_o, lcd_e_o;
    logic [7:0] lcd_data_o;

    lcd_digit_writer #(
        .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
        .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .LINE_ADDR(LINE_ADDR)
    ) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
        .enco1_i(enco1_i), .enco2_i(enco2_i), .enco3_i(enco3_i),
        .ready_o(ready_o), .done_o(done_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
        .lcd_e_o(lcd_e_o), .lcd_data_o(lcd_data_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int stim_mode = 0;

    // Observation vector: {ready, done, rw, rs, e, data}
    function automatic logic [12:0] vec(input logic rdy, input logic dn, input logic rs,
                                        input logic e, input logic [7:0] d);
        return {rdy, dn, 1'b0, rs, e, d};
    endfunction

    task automatic check(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {ready_o, done_o, lcd_rw_o, lcd_rs_o, lcd_e_o, lcd_data_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Input disturbance applied after each checked cycle while the DUT is busy.
    task automatic poke();
        case (stim_mode)
            1: start_i = 1'b0;
            2: begin
                start_i = 1'($urandom_range(0, 1));
                enco1_i = 8'($urandom);
                enco2_i = 8'($urandom);
                enco3_i = 8'($urandom);
            end
            3: begin
                start_i = 1'b0;
                enco1_i = 8'h39;
                enco2_i = 8'h39;
                enco3_i = 8'h39;
            end
            default: ;
        endcase
    endtask

    task automatic expect_part(input string tag, input logic rs, input logic [7:0] d, input int n);
        logic eb;
        for (int c = 0; c < n; c++) begin
            step();
            eb = (c >= int'(T_SETUP)) && (c < int'(T_SETUP + T_PULSE));
            check(tag, vec(1'b0, 1'b0, rs, eb, d));
            poke();
        end
    endtask

    task automatic expect_byte(input string tag, input logic rs, input logic [7:0] d, input int wt);
        expect_part(tag, rs, d, int'(T_SETUP + T_PULSE) + wt);
    endtask

    task automatic expect_init();
        for (int c = 0; c < int'(T_POWERUP); c++) begin
            step();
            check("pwrup", vec(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            poke();
        end
        expect_byte("init_38", 1'b0, 8'h38, int'(T_EXEC));
        expect_byte("init_0c", 1'b0, 8'h0C, int'(T_EXEC));
        expect_byte("init_01", 1'b0, 8'h01, int'(T_CLEAR));
        expect_byte("init_06", 1'b0, 8'h06, int'(T_EXEC));
        step();
        check("init_ready", vec(1'b1, 1'b0, 1'b0, 1'b0, 8'h06));
    endtask

    task automatic expect_write(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        expect_byte("wr_addr", 1'b0, {1'b1, LINE_ADDR}, int'(T_EXEC));
        expect_byte("wr_d1", 1'b1, b1, int'(T_EXEC));
        expect_byte("wr_d2", 1'b1, b2, int'(T_EXEC));
        expect_byte("wr_d3", 1'b1, b3, int'(T_EXEC));
        step();
        check("wr_done", vec(1'b1, 1'b1, 1'b1, 1'b0, b3));
    endtask

    initial begin
        logic [7:0] r1, r2, r3;

        // Reset: everything low even with start requested
        start_i = 1'b1;
        enco1_i = 8'h35;
        repeat (3) step();
        check("reset", vec(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

        // Power-up and init with random start pulses that must be ignored
        start_i   = 1'b0;
        rst_n_i   = 1'b1;
        stim_mode = 2;
        expect_init();
        stim_mode = 0;
        start_i   = 1'b0;
        repeat (3) begin
            step();
            check("idle_after_init", vec(1'b1, 1'b0, 1'b0, 1'b0, 8'h06));
        end

        // Basic digit write
        start_i = 1'b1;
        enco1_i = 8'h31;
        enco2_i = 8'h32;
        enco3_i = 8'h33;
        stim_mode = 1;
        expect_write(8'h31, 8'h32, 8'h33);
        step();
        check("idle_after_wr", vec(1'b1, 1'b0, 1'b1, 1'b0, 8'h33));

        // Inputs change right after acceptance: latched bytes must be written
        start_i = 1'b1;
        enco1_i = 8'h31;
        enco2_i = 8'h32;
        enco3_i = 8'h33;
        stim_mode = 3;
        expect_write(8'h31, 8'h32, 8'h33);
        start_i = 1'b0;
        step();
        check("idle_after_latch", vec(1'b1, 1'b0, 1'b1, 1'b0, 8'h33));

        // Random bytes (non-digits included) with stray starts during WRITE
        for (int k = 0; k < 4; k++) begin
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            start_i = 1'b1;
            enco1_i = r1;
            enco2_i = r2;
            enco3_i = r3;
            stim_mode = 2;
            expect_write(r1, r2, r3);
            start_i = 1'b0;
            step();
            check("idle_after_rand", vec(1'b1, 1'b0, 1'b1, 1'b0, r3));
        end

        // Reset during PULSE of the second character
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        start_i = 1'b1;
        enco1_i = r1;
        enco2_i = r2;
        enco3_i = r3;
        stim_mode = 1;
        expect_byte("abort_addr", 1'b0, {1'b1, LINE_ADDR}, int'(T_EXEC));
        expect_byte("abort_d1", 1'b1, r1, int'(T_EXEC));
        expect_part("abort_d2", 1'b1, r2, int'(T_SETUP) + 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rst_abort_async", vec(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        step();
        check("rst_abort_hold", vec(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        rst_n_i   = 1'b1;
        stim_mode = 2;
        expect_init();

        // start_i held high: back-to-back writes, done every 41st cycle
        stim_mode = 0;
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        start_i = 1'b1;
        enco1_i = r1;
        enco2_i = r2;
        enco3_i = r3;
        repeat (3) expect_write(r1, r2, r3);
        start_i = 1'b0;
        step();
        check("idle_after_b2b", vec(1'b1, 1'b0, 1'b1, 1'b0, r3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_digit_writer.md
Name: lcd_digit_writer

Overview:
Sequencer that drives an HD44780-compatible character LCD in 8-bit mode with three ASCII digit bytes produced by the BCD-to-ASCII encoder stage.
- After reset it runs the LCD power-up/init sequence autonomously.
- On each start strobe it latches the three bytes, writes a DDRAM address command, then writes the three characters with correct E-strobe timing.
- It sits between the encoder and the LCD pins inside wb_lcd.

Parameters:
- T_POWERUP, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- T_SETUP, 3: cycles RS/data are stable before E rises.
- T_PULSE, 12: cycles E is held high.
- T_EXEC, 2000: post-pulse wait cycles for every command and data write except clear.
- T_CLEAR, 82000: post-pulse wait cycles for the clear command 0x01.
- LINE_ADDR, 7'h00: DDRAM address of the first digit.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  write request, sampled only while ready_o=1.
- enco1_i  in  8  ASCII byte for the first (leftmost) digit.
- enco2_i  in  8  ASCII byte for the second digit.
- enco3_i  in  8  ASCII byte for the third digit.
- ready_o  out  1  idle and able to accept start_i.
- done_o  out  1  one-cycle pulse when a digit write sequence completes.
- lcd_rs_o  out  1  LCD register select (0 = command, 1 = data).
- lcd_rw_o  out  1  LCD read/write, constant 0.
- lcd_e_o  out  1  LCD enable strobe.
- lcd_data_o  out  8  LCD data bus.

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (rst_n_i). While rst_n_i=0 all outputs are 0, the FSM is in PWRUP, and counters are cleared. Reset asserted mid-transfer aborts immediately: E drops to 0 in the same instant. After release the full power-up and init sequence reruns.
- Counters: all counters are 20-bit. Every T_* value must be ≤ 2^20−1 and ≥ 1.
- Top FSM states: PWRUP → INIT → IDLE → WRITE → IDLE.
  - PWRUP: waits T_POWERUP cycles, counting from the first rising edge with rst_n_i=1.
  - INIT: issues commands 0x38, 0x0C, 0x01, 0x06 in that order, all with RS=0.
  - IDLE: ready_o=1.
  - WRITE: issues 0x80|{1'b0,LINE_ADDR} with RS=0, then the latched enco1, enco2, enco3 bytes with RS=1.
- Transfer sub-FSM for every byte: SETUP → PULSE → WAIT.
  - SETUP: T_SETUP cycles, E=0, RS and data driven.
  - PULSE: T_PULSE cycles, E=1.
  - WAIT: T_EXEC cycles (T_CLEAR for the 0x01 command), E=0.
  - Total per byte: T_SETUP+T_PULSE+T_wait cycles.
  - lcd_data_o and lcd_rs_o hold their value through WAIT and change only at the next SETUP.
  - After the last WAIT of INIT or WRITE, the FSM enters IDLE. lcd_data_o/lcd_rs_o keep their last value.
- Start handshake:
  - start_i is accepted on a rising edge where ready_o=1 and start_i=1.
  - On acceptance, enco1_i..enco3_i are latched into internal registers; later input changes do not affect the sequence in progress.
  - ready_o drops on the next cycle, and SETUP of the address byte begins that same cycle.
  - start_i while ready_o=0 (PWRUP, INIT, WRITE) is ignored and not queued.
- done_o:
  - Pulses 1 for exactly one cycle, in the first IDLE cycle after WRITE. ready_o=1 in that same cycle.
  - Never pulses after INIT.
  - start_i held high continuously restarts a new write on the done_o cycle, since ready_o=1 there.
- Bytes are passed unmodified; non-digit ASCII values are written as-is.
- lcd_rw_o=0 at all times. The LCD busy flag is never read; timing is purely cycle-counted.

Test Plan:
Bench overrides: T_POWERUP=10, T_SETUP=2, T_PULSE=3, T_EXEC=5, T_CLEAR=8, LINE_ADDR=7'h40.
1. Reset release:
   - ready_o=0 and E=0 for 10 cycles.
   - E pulses 4 times, 3 cycles each, with data 0x38, 0x0C, 0x01, 0x06 and RS=0.
   - ready_o rises exactly 53 cycles after the first edge with rst_n_i=1; done_o stays 0.
2. Start with enco=0x31,0x32,0x33:
   - ready_o falls next cycle.
   - Bytes 0xC0 (RS=0), then 0x31, 0x32, 0x33 (RS=1), 10 cycles each.
   - done_o pulses one cycle 40 cycles after acceptance, coincident with ready_o=1.
3. Change enco inputs to 0x39 one cycle after acceptance -> written bytes remain 0x31, 0x32, 0x33.
4. Pulse start_i during INIT and during WRITE -> no extra transfers and no extra done_o.
5. Assert rst_n_i low during the PULSE phase of the second character:
   - lcd_e_o=0 and all outputs 0 immediately.
   - After release, the full 53-cycle init repeats.
6. Hold start_i=1 permanently after init -> back-to-back 40-cycle write sequences, with done_o every 41st cycle.
